// File: rtl/dma_dmem_req_data_path_if.sv
// rtl/dma_dmem_req_data_path_if.sv - request/response bundle for the tile DMA DMEM datapath
interface dma_dmem_req_data_path_if #(
   parameter int data_width_p      = 32,
   parameter int dmem_addr_width_p = 10
);
   localparam int mask_width_lp = data_width_p / 8;

   // DMA local request generator side
   logic                         gen_sel_i;
   logic                         gen_w_i;
   logic [dmem_addr_width_p-1:0] gen_addr_i;
   logic [mask_width_lp-1:0]     gen_mask_i;
   logic [data_width_p-1:0]      gen_data_i;

   // network RX side
   logic                         rx_sel_i;
   logic                         rx_w_i;
   logic [dmem_addr_width_p-1:0] rx_addr_i;
   logic [mask_width_lp-1:0]     rx_mask_i;
   logic [data_width_p-1:0]      rx_data_i;

   // core DMEM port
   logic                         core_w_o;
   logic [dmem_addr_width_p-1:0] core_addr_o;
   logic [mask_width_lp-1:0]     core_mask_o;
   logic [data_width_p-1:0]      core_data_o;
   logic [data_width_p-1:0]      dmem_rdata_i;

   // capture control and remote request generator FIFO port
   logic                         push_not_pull_i;
   logic                         all_local_sent_i;
   logic                         fifo_v_o;
   logic [data_width_p-1:0]      fifo_data_o;
   logic                         fifo_yumi_i;
   logic                         fifo_ready_o;
   logic                         overflow_o;

   // the tile-side environment that drives requests and consumes the FIFO
   modport master (
      output gen_sel_i, gen_w_i, gen_addr_i, gen_mask_i, gen_data_i,
      output rx_sel_i, rx_w_i, rx_addr_i, rx_mask_i, rx_data_i,
      output dmem_rdata_i, push_not_pull_i, all_local_sent_i, fifo_yumi_i,
      input  core_w_o, core_addr_o, core_mask_o, core_data_o,
      input  fifo_v_o, fifo_data_o, fifo_ready_o, overflow_o
   );

   // the datapath itself
   modport slave (
      input  gen_sel_i, gen_w_i, gen_addr_i, gen_mask_i, gen_data_i,
      input  rx_sel_i, rx_w_i, rx_addr_i, rx_mask_i, rx_data_i,
      input  dmem_rdata_i, push_not_pull_i, all_local_sent_i, fifo_yumi_i,
      output core_w_o, core_addr_o, core_mask_o, core_data_o,
      output fifo_v_o, fifo_data_o, fifo_ready_o, overflow_o
   );
endinterface

// File: rtl/dma_dmem_req_data_path.sv
// rtl/dma_dmem_req_data_path.sv - DMEM request steering and DMA push read-data capture FIFO
module dma_dmem_req_data_path #(
   parameter int data_width_p      = 32,
   parameter int dmem_addr_width_p = 10,
   parameter int fifo_els_p        = 3
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   dma_dmem_req_data_path_if.slave bus
);
   localparam int mask_width_lp = data_width_p / 8;
   localparam int ptr_width_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
   localparam int cnt_width_lp  = $clog2(fifo_els_p + 1);

   localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(fifo_els_p - 1);
   localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(fifo_els_p);

   logic                         w_mux;
   logic [dmem_addr_width_p-1:0] addr_mux;
   logic [mask_width_lp-1:0]     mask_mux;
   logic [data_width_p-1:0]      data_mux;

   logic                         cap_r;
   logic                         overflow_r;
   logic [ptr_width_lp-1:0]      wr_ptr_r;
   logic [ptr_width_lp-1:0]      rd_ptr_r;
   logic [cnt_width_lp-1:0]      count_r;
   logic [data_width_p-1:0]      mem_r [fifo_els_p];

   logic                         fifo_v;
   logic                         fifo_ready;
   logic                         enq;
   logic                         deq;

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
      return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
   endfunction

   // AND-OR steering of the two one-hot requesters onto the core DMEM port
   always_comb begin
      w_mux    = (bus.gen_sel_i & bus.gen_w_i) | (bus.rx_sel_i & bus.rx_w_i);
      addr_mux = ({dmem_addr_width_p{bus.gen_sel_i}} & bus.gen_addr_i)
               | ({dmem_addr_width_p{bus.rx_sel_i}}  & bus.rx_addr_i);
      mask_mux = ({mask_width_lp{bus.gen_sel_i}} & bus.gen_mask_i)
               | ({mask_width_lp{bus.rx_sel_i}}  & bus.rx_mask_i);
      data_mux = ({data_width_p{bus.gen_sel_i}} & bus.gen_data_i)
               | ({data_width_p{bus.rx_sel_i}}  & bus.rx_data_i);
   end

   assign bus.core_w_o    = w_mux;
   assign bus.core_addr_o = addr_mux;
   assign bus.core_mask_o = mask_mux;
   assign bus.core_data_o = data_mux;

   // FIFO status; a same-cycle dequeue never frees room for that cycle's capture
   assign fifo_v     = (count_r != '0);
   assign fifo_ready = (count_r != full_cnt_lp);
   assign enq        = cap_r & fifo_ready;
   assign deq        = bus.fifo_yumi_i & fifo_v;

   assign bus.fifo_v_o     = fifo_v;
   assign bus.fifo_ready_o = fifo_ready;
   assign bus.fifo_data_o  = mem_r[rd_ptr_r];
   assign bus.overflow_o   = overflow_r;

   // mark the cycle in which DMEM returns data for a granted DMA push read
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cap_r <= 1'b0;
      end else begin
         cap_r <= bus.gen_sel_i & ~bus.all_local_sent_i & bus.push_not_pull_i;
      end
   end

   // FIFO storage; contents are don't-care while empty so no reset is needed
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_r[wr_ptr_r] <= bus.dmem_rdata_i;
      end
   end

   // pointer, occupancy and sticky overflow tracking
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (deq) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({enq, deq})
            2'b10:   count_r <= count_r + cnt_width_lp'(1);
            2'b01:   count_r <= count_r - cnt_width_lp'(1);
            default: count_r <= count_r;
         endcase
         if (cap_r && !fifo_ready) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // both requesters granted at once would corrupt the core request
   a_one_hot_sel: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(bus.gen_sel_i && bus.rx_sel_i));

   // the consumer may only dequeue a valid head
   a_yumi_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(bus.fifo_yumi_i && !fifo_v));
endmodule

// File: tb/tb_dma_dmem_req_data_path.sv
// tb/tb_dma_dmem_req_data_path.sv - directed self-checking bench for dma_dmem_req_data_path
module tb_dma_dmem_req_data_path;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   dma_dmem_req_data_path_if #(.data_width_p(32), .dmem_addr_width_p(10)) bus ();

   dma_dmem_req_data_path #(
      .data_width_p(32), .dmem_addr_width_p(10), .fifo_els_p(3)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // grant a DMA push read, then present the DMEM word on the following cycle
   task automatic cap_word(input logic [31:0] w, input logic yumi);
      bus.gen_sel_i       = 1'b1;
      bus.push_not_pull_i = 1'b1;
      step();
      bus.gen_sel_i    = 1'b0;
      bus.dmem_rdata_i = w;
      bus.fifo_yumi_i  = yumi;
      step();
      bus.fifo_yumi_i  = 1'b0;
   endtask

   task automatic pop();
      bus.fifo_yumi_i = 1'b1;
      step();
      bus.fifo_yumi_i = 1'b0;
   endtask

   initial begin
      rst_n                = 1'b0;
      bus.gen_sel_i        = 1'b0;
      bus.gen_w_i          = 1'b0;
      bus.gen_addr_i       = '0;
      bus.gen_mask_i       = '0;
      bus.gen_data_i       = '0;
      bus.rx_sel_i         = 1'b0;
      bus.rx_w_i           = 1'b0;
      bus.rx_addr_i        = '0;
      bus.rx_mask_i        = '0;
      bus.rx_data_i        = '0;
      bus.dmem_rdata_i     = '0;
      bus.push_not_pull_i  = 1'b0;
      bus.all_local_sent_i = 1'b0;
      bus.fifo_yumi_i      = 1'b0;
      #3;
      chk("rst_fifo_v", 32'(bus.fifo_v_o), 32'd0);
      chk("rst_ready", 32'(bus.fifo_ready_o), 32'd1);
      chk("rst_overflow", 32'(bus.overflow_o), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // request steering
      bus.gen_w_i    = 1'b1;
      bus.gen_addr_i = 10'h02A;
      bus.gen_mask_i = 4'hF;
      bus.gen_data_i = 32'hDEADBEEF;
      bus.rx_w_i     = 1'b0;
      bus.rx_addr_i  = 10'h3C5;
      bus.rx_mask_i  = 4'h6;
      bus.rx_data_i  = 32'hCAFEF00D;
      bus.gen_sel_i  = 1'b1;
      #1;
      chk("mux_gen_addr", 32'(bus.core_addr_o), 32'h02A);
      chk("mux_gen_data", bus.core_data_o, 32'hDEADBEEF);
      chk("mux_gen_w", 32'(bus.core_w_o), 32'd1);
      chk("mux_gen_mask", 32'(bus.core_mask_o), 32'hF);
      bus.gen_sel_i = 1'b0;
      bus.rx_sel_i  = 1'b1;
      #1;
      chk("mux_rx_addr", 32'(bus.core_addr_o), 32'h3C5);
      chk("mux_rx_data", bus.core_data_o, 32'hCAFEF00D);
      chk("mux_rx_w", 32'(bus.core_w_o), 32'd0);
      chk("mux_rx_mask", 32'(bus.core_mask_o), 32'h6);
      bus.rx_sel_i = 1'b0;
      #1;
      chk("mux_none", {bus.core_data_o[31:16], 1'b0, bus.core_w_o, bus.core_addr_o, bus.core_mask_o},
          32'd0);
      chk("mux_none_data", bus.core_data_o, 32'd0);
      step();
      chk("no_cap_pull", 32'(bus.fifo_v_o), 32'd0);

      // single capture, two cycles after the grant
      cap_word(32'h11223344, 1'b0);
      chk("cap_v", 32'(bus.fifo_v_o), 32'd1);
      chk("cap_data", bus.fifo_data_o, 32'h11223344);
      pop();
      chk("cap_drained", 32'(bus.fifo_v_o), 32'd0);

      // suppression by pull mode and by all_local_sent
      bus.push_not_pull_i = 1'b0;
      bus.gen_sel_i       = 1'b1;
      bus.dmem_rdata_i    = 32'h99999999;
      step();
      step();
      chk("supp_pull", 32'(bus.fifo_v_o), 32'd0);
      bus.push_not_pull_i  = 1'b1;
      bus.all_local_sent_i = 1'b1;
      step();
      step();
      chk("supp_all_sent", 32'(bus.fifo_v_o), 32'd0);
      bus.gen_sel_i        = 1'b0;
      bus.all_local_sent_i = 1'b0;
      step();
      chk("supp_final", 32'(bus.fifo_v_o), 32'd0);

      // fill, overflow and in-order drain
      cap_word(32'hA, 1'b0);
      cap_word(32'hB, 1'b0);
      chk("fill2_ready", 32'(bus.fifo_ready_o), 32'd1);
      cap_word(32'hC, 1'b0);
      chk("full_ready", 32'(bus.fifo_ready_o), 32'd0);
      chk("full_no_ovf", 32'(bus.overflow_o), 32'd0);
      cap_word(32'hD, 1'b0);
      chk("ovf_set", 32'(bus.overflow_o), 32'd1);
      chk("ovf_head", bus.fifo_data_o, 32'hA);
      pop();
      chk("drain_b", bus.fifo_data_o, 32'hB);
      chk("drain_ready", 32'(bus.fifo_ready_o), 32'd1);
      pop();
      chk("drain_c", bus.fifo_data_o, 32'hC);
      pop();
      chk("drain_empty", 32'(bus.fifo_v_o), 32'd0);
      chk("ovf_sticky", 32'(bus.overflow_o), 32'd1);

      // simultaneous capture and dequeue with one entry held
      cap_word(32'h55, 1'b0);
      cap_word(32'h66, 1'b1);
      chk("conc_v", 32'(bus.fifo_v_o), 32'd1);
      chk("conc_head", bus.fifo_data_o, 32'h66);
      chk("conc_ready", 32'(bus.fifo_ready_o), 32'd1);
      pop();
      chk("conc_one_left", 32'(bus.fifo_v_o), 32'd0);

      // asynchronous reset with two entries in flight
      cap_word(32'h77, 1'b0);
      cap_word(32'h88, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_v", 32'(bus.fifo_v_o), 32'd0);
      chk("arst_ovf", 32'(bus.overflow_o), 32'd0);
      chk("arst_ready", 32'(bus.fifo_ready_o), 32'd1);
      step();
      rst_n = 1'b1;
      step();

      // dequeue while full does not make room for that cycle's capture
      cap_word(32'h1, 1'b0);
      cap_word(32'h2, 1'b0);
      cap_word(32'h3, 1'b0);
      cap_word(32'h4, 1'b1);
      chk("fullpop_ovf", 32'(bus.overflow_o), 32'd1);
      chk("fullpop_head", bus.fifo_data_o, 32'h2);
      chk("fullpop_ready", 32'(bus.fifo_ready_o), 32'd1);
      pop();
      chk("fullpop_next", bus.fifo_data_o, 32'h3);
      pop();
      chk("fullpop_empty", 32'(bus.fifo_v_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
